cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) among NUM_REQ functional-unit result ports in the Tomasulo core.
- Picks at most one requester per cycle using round-robin, starting from a rotating pointer.
- Broadcasts the winner's tag and data on registered CDB outputs one cycle after the grant.
- Downstream consumers (reservation stations, register-status table, tag FIFOs) snoop cdb_valid/cdb_tag/cdb_data.

---
 rtl/cdb_pkg.sv | 21 ++
 rtl/cdb_arbiter_rr_picker.sv | 39 +++
 rtl/cdb_arbiter.sv | 106 ++++++++++
 tb/tb_cdb_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared common-data-bus types and constants for the Tomasulo core.
// Consumers (reservation stations, register status, tag FIFOs) reuse cdb_bus_t.
package cdb_pkg;

   localparam int CDB_TAG_W  = 4;
   localparam int CDB_DATA_W = 32;

   localparam logic [CDB_TAG_W-1:0] NO_TAG = '0;

   typedef struct packed {
      logic                  valid;
      logic [CDB_TAG_W-1:0]  tag;
      logic [CDB_DATA_W-1:0] data;
   } cdb_bus_t;

   // Index width for an N-entry requester vector, never narrower than one bit.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Produces a one-hot grant and its encoded index; all-zero grant when disabled.
module rr_picker
   import cdb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PW      = ptr_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [PW-1:0]      idx
);

   int          k;
   logic [PW-1:0] kk;
   logic        found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      k     = 0;
      kk    = '0;
      if (en) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            k  = (int'(ptr) + i) % NUM_REQ;
            kk = PW'(k);
            if (!found && req[kk]) begin
               found     = 1'b1;
               grant[kk] = 1'b1;
               idx       = kk;
            end
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one round-robin grant per cycle, registered broadcast one cycle later.
// Optional macro CDB_PRIO_EN: requester 0 (load unit) overrides round-robin without moving the pointer.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int TAG_WIDTH  = CDB_TAG_W,
   parameter int DATA_WIDTH = CDB_DATA_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          cdb_stall,
   input  logic                          flush,
   output logic                          cdb_valid,
   output logic [TAG_WIDTH-1:0]          cdb_tag,
   output logic [DATA_WIDTH-1:0]         cdb_data
);

   localparam int PW = ptr_width(NUM_REQ);

   logic [PW-1:0]         rr_ptr;
   logic [PW-1:0]         next_ptr;
   logic                  grant_en;
   logic [NUM_REQ-1:0]    rr_grant;
   logic [PW-1:0]         rr_idx;
   logic [NUM_REQ-1:0]    grant;
   logic [PW-1:0]         win;
   logic                  any_grant;
   logic                  move_ptr;
   logic [TAG_WIDTH-1:0]  sel_tag;
   logic [DATA_WIDTH-1:0] sel_data;
   cdb_bus_t              cdb_q;

   // Reset is folded in so req_ready is quiet while reset is held.
   assign grant_en = !reset && !cdb_stall && !flush;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_rr_picker (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .en    (grant_en),
      .grant (rr_grant),
      .idx   (rr_idx)
   );

   always_comb begin
      grant    = rr_grant;
      win      = rr_idx;
      move_ptr = 1'b1;
`ifdef CDB_PRIO_EN
      if (grant_en && req_valid[0]) begin
         grant    = '0;
         grant[0] = 1'b1;
         win      = '0;
         move_ptr = 1'b0;
      end
`endif
   end

   assign any_grant = |grant;
   assign req_ready = grant;
   assign next_ptr  = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);

   // grant is one-hot, so an OR-reduction mux is enough.
   always_comb begin
      sel_tag  = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_tag  = sel_tag  | req_tag[i*TAG_WIDTH +: TAG_WIDTH];
            sel_data = sel_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr     <= '0;
         cdb_q.valid <= 1'b0;
         cdb_q.tag   <= NO_TAG;
         cdb_q.data  <= '0;
      end else if (flush) begin
         rr_ptr      <= '0;
         cdb_q.valid <= 1'b0;
      end else if (any_grant) begin
         if (move_ptr) rr_ptr <= next_ptr;
         cdb_q.valid <= 1'b1;
         cdb_q.tag   <= CDB_TAG_W'(sel_tag);
         cdb_q.data  <= CDB_DATA_W'(sel_data);
      end else begin
         // Tag and data hold; they are don't-care while valid is low.
         cdb_q.valid <= 1'b0;
      end
   end

   assign cdb_valid = cdb_q.valid;
   assign cdb_tag   = TAG_WIDTH'(cdb_q.tag);
   assign cdb_data  = DATA_WIDTH'(cdb_q.data);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic
// against a queue-free requester model that applies the arbitration rules directly.
module tb_cdb_arbiter;

   localparam int N  = 4;
   localparam int TW = 4;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [N*TW-1:0]   req_tag;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic              cdb_stall;
   logic              flush;
   logic              cdb_valid;
   logic [TW-1:0]     cdb_tag;
   logic [DW-1:0]     cdb_data;

   always #5 clk = ~clk;

   cdb_arbiter #(
      .NUM_REQ    (N),
      .TAG_WIDTH  (TW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_tag   (req_tag),
      .req_data  (req_data),
      .req_ready (req_ready),
      .cdb_stall (cdb_stall),
      .flush     (flush),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Requester model: each unit holds its result until granted.
   logic          pend  [N];
   logic [TW-1:0] ptag  [N];
   logic [DW-1:0] pdata [N];

   // Reference arbiter state.
   int            m_ptr;
   logic          e_valid;
   logic [TW-1:0] e_tag;
   logic [DW-1:0] e_data;
   int            g;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic stall_i, input logic flush_i);
      if (stall_i || flush_i) return -1;
`ifdef CDB_PRIO_EN
      if (pend[0]) return 0;
`endif
      for (int s = 0; s < N; s++) begin
         if (pend[(m_ptr + s) % N]) return (m_ptr + s) % N;
      end
      return -1;
   endfunction

   task automatic new_req(input int i);
      pend[i]  = 1'b1;
      ptag[i]  = TW'($urandom);
      pdata[i] = $urandom;
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]            = pend[i];
         req_tag[i*TW +: TW]     = ptag[i];
         req_data[i*DW +: DW]    = pdata[i];
      end
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      e_valid = 1'b0;
      e_tag   = '0;
      e_data  = '0;
   endtask

   // Called at a falling edge; returns at the next falling edge with outputs checked.
   task automatic cycle(input logic stall_i, input logic flush_i, input bit refill, output int gw);
      logic [63:0] exp_rdy;
      cdb_stall = stall_i;
      flush     = flush_i;
      drive();
      #1;
      gw      = pick(stall_i, flush_i);
      exp_rdy = (gw < 0) ? 64'd0 : (64'd1 << gw);
      chk("req_ready", 64'(req_ready), exp_rdy);
      @(posedge clk);
      @(negedge clk);
      if (flush_i) begin
         e_valid = 1'b0;
         m_ptr   = 0;
      end else if (gw >= 0) begin
         e_valid = 1'b1;
         e_tag   = ptag[gw];
         e_data  = pdata[gw];
`ifdef CDB_PRIO_EN
         if (gw != 0) m_ptr = (gw + 1) % N;
`else
         m_ptr = (gw + 1) % N;
`endif
         pend[gw] = 1'b0;
         if (refill) new_req(gw);
      end else begin
         e_valid = 1'b0;
      end
      chk("cdb_valid", 64'(cdb_valid), 64'(e_valid));
      if (e_valid) begin
         chk("cdb_tag", 64'(cdb_tag), 64'(e_tag));
         chk("cdb_data", 64'(cdb_data), 64'(e_data));
      end
      cdb_stall = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      cdb_stall = 1'b0;
      flush     = 1'b0;
      for (int i = 0; i < N; i++) new_req(i);
      drive();
      model_reset();
      #12;
      chk("rst_valid", 64'(cdb_valid), 64'd0);
      chk("rst_tag", 64'(cdb_tag), 64'd0);
      chk("rst_data", 64'(cdb_data), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      clear_reqs();

      // Single requester on unit 2.
      pend[2] = 1'b1; ptag[2] = 4'd5; pdata[2] = 32'hDEAD;
      cycle(1'b0, 1'b0, 1'b0, g);
      chk("t1_tag", 64'(cdb_tag), 64'd5);
      chk("t1_data", 64'(cdb_data), 64'hDEAD);

      // Pointer sits at 3: wrap-around between units 3 and 0.
      new_req(0); new_req(3);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, g);

      // Move pointer to 2, then flush with units 0 and 2 pending.
      new_req(1);
      cycle(1'b0, 1'b0, 1'b0, g);
      new_req(0); new_req(2);
      cycle(1'b0, 1'b1, 1'b0, g);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, g);

      // Stall two cycles with unit 1 waiting, then release.
      new_req(1);
      repeat (2) cycle(1'b1, 1'b0, 1'b0, g);
      cycle(1'b0, 1'b0, 1'b0, g);

      // Pointer back to 0, then all four saturated for 8 cycles.
      cycle(1'b0, 1'b1, 1'b0, g);
      for (int i = 0; i < N; i++) new_req(i);
      repeat (8) cycle(1'b0, 1'b0, 1'b1, g);
      repeat (4) cycle(1'b0, 1'b0, 1'b0, g);

      // Units 0 and 1 continuously valid with the pointer at 1 (default build).
      cycle(1'b0, 1'b1, 1'b0, g);
      new_req(0);
      cycle(1'b0, 1'b0, 1'b0, g);
      new_req(0); new_req(1);
      repeat (3) cycle(1'b0, 1'b0, 1'b1, g);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, g);

      // Reset asserted while a broadcast is on the bus.
      new_req(3);
      cycle(1'b0, 1'b0, 1'b0, g);
      reset = 1'b1;
      #1;
      chk("midrst_valid", 64'(cdb_valid), 64'd0);
      chk("midrst_ready", 64'(req_ready), 64'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      // Randomized traffic with occasional stall and flush.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom_range(0, 9) < 4)) new_req(i);
         end
         cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0), 1'b0, g);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
